frame_buffer: RTL and testbench
===============================

# frame_buffer

Dual-port pixel store that receives the GPU's framebuffer write stream (`fb_x`, `fb_y`, `fb_color`, `fb_write`) and serves one-cycle-latency pixel reads to the display scanout. With double buffering compiled in, the GPU renders into a back buffer while scanout reads the front buffer. A controller-requested swap takes effect only during vertical blank. The block sits between `gpu` and the video timing/scanout logic.

## Interface
- `FB_WIDTH`, 400, pixels per line
- `FB_HEIGHT`, 240, lines per frame
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `fb_x`  in  $clog2(FB_WIDTH)+1  write x coordinate
- `fb_y`  in  $clog2(FB_HEIGHT)+1  write y coordinate
- `fb_color`  in  16  write pixel (RGB555 + bit0 transparency; stored verbatim)
- `fb_write`  in  1  write strobe, one pixel per cycle
- `rd_x`  in  $clog2(FB_WIDTH)+1  scanout read x
- `rd_y`  in  $clog2(FB_HEIGHT)+1  scanout read y
- `rd_en`  in  1  scanout read request
- `rd_color`  out  16  read data
- `rd_valid`  out  1  high for one cycle when `rd_color` holds data for the previous cycle's request
- `vblank`  in  1  high while display is in vertical blank
- `ctrl_swap`  in  1  swap request; rising-edge sensitive
- `swap_pending`  out  1  swap requested but not yet performed
- `front_buffer`  out  1  index of buffer currently scanned out

## Operation
- Storage: 2 × FB_WIDTH·FB_HEIGHT × 16-bit words (1 × without double buffering). Buffer base = index·FB_WIDTH·FB_HEIGHT. Address = base + y·FB_WIDTH + x. Address arithmetic width must cover 2·FB_WIDTH·FB_HEIGHT. Contents are not reset.
- Writes target the back buffer (`!front_buffer`). A write is performed only if `fb_write && fb_x < FB_WIDTH && fb_y < FB_HEIGHT`. Out-of-bounds writes are silently dropped.
- Reads target the front buffer. An out-of-bounds read (`rd_x >= FB_WIDTH` or `rd_y >= FB_HEIGHT`) returns 0 with `rd_valid` still asserted.
- Swap FSM:
  - States: SHOWING (`swap_pending=0`) and PENDING (`swap_pending=1`).
  - Edge detect: registered `old_ctrl_swap` (reset 0); `command_swap = !old_ctrl_swap && ctrl_swap`.
  - SHOWING → PENDING on `command_swap`.
  - PENDING → SHOWING on the first edge where `vblank` is sampled high. At that edge `front_buffer` toggles.
  - `command_swap` while PENDING is ignored; requests do not queue.
- Simultaneous events:
  - A write on the swap edge goes to the pre-swap back buffer.
  - A read on the swap edge uses the pre-swap front buffer.
  - A write and a read to the same physical address in the same cycle (single-buffer only) return the old data (read-first).
- Reset mid-PENDING: the pending swap is discarded, `front_buffer` returns to 0, and any in-flight read produces no `rd_valid`.

## Timing
- Reset values: `rd_color=0`, `rd_valid=0`, `swap_pending=0`, `front_buffer=0`.
- Write: committed at the sampling edge; readable by a read issued on the next cycle.
- Read latency: exactly 1 cycle. `rd_en` sampled at edge N → `rd_color`/`rd_valid` valid after edge N. Back-to-back reads sustain one pixel per cycle.
- `rd_color` holds its last value when `rd_valid=0`.
- Swap latency: `ctrl_swap` rising at edge N → `swap_pending=1` after N. Swap occurs at the first edge M > N with `vblank=1`. `ctrl_swap` and `vblank` rising together → swap at N+1 at the earliest.
- Memory is inferable as block RAM: a registered read port, a separate write port, and no combinational read path.

## Configuration
- `FB_DOUBLE_BUFFER_EN` defined: two buffers; swap FSM as above.
- `FB_DOUBLE_BUFFER_EN` undefined:
  - Single buffer; reads and writes share it.
  - `front_buffer` is tied to 0 and `swap_pending` is tied to 0.
  - `ctrl_swap`/`vblank` are ignored.
  - Storage halves; read-first collision rule applies.

## Test plan
- Reset, then write (3,5)=0x7FFF. Read (3,5) before a swap → front buffer data (not 0x7FFF). Swap in vblank, then read (3,5) → 0x7FFF, with `rd_valid` one cycle after `rd_en`.
- Write `fb_x=400`, `fb_y=0`, color 0xFFFF. Swap, then read (0,1) and (399,0) → neither changed. Read `rd_x=400` → `rd_color=0`, `rd_valid=1`.
- Pulse `ctrl_swap` with `vblank=0` for 100 cycles → `swap_pending=1`, `front_buffer` unchanged. Raise `vblank` → `front_buffer` toggles at that edge and `swap_pending=0` in the same cycle.
- Second `ctrl_swap` pulse while pending, then one vblank → exactly one toggle. Holding `ctrl_swap` high across two vblanks → only one toggle.
- Assert `reset` while pending with a read in flight → next cycle `swap_pending=0`, `front_buffer=0`, `rd_valid=0`.
- Single-buffer build: write and read (10,10) in the same cycle, old value 0x0001, new 0x00FF → read returns 0x0001; read next cycle returns 0x00FF.

Source files
------------

// File: rtl/frame_buffer_if.sv
// frame_buffer_if: GPU pixel write stream, scanout read port and swap control for frame_buffer.
interface frame_buffer_if #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240
);
    localparam int XW = $clog2(FB_WIDTH) + 1;
    localparam int YW = $clog2(FB_HEIGHT) + 1;
    logic [XW-1:0] fb_x;
    logic [YW-1:0] fb_y;
    logic [15:0]   fb_color;
    logic          fb_write;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_en;
    logic [15:0]   rd_color;
    logic          rd_valid;
    logic          vblank;
    logic          ctrl_swap;
    logic          swap_pending;
    logic          front_buffer;
    modport master (
        output fb_x, fb_y, fb_color, fb_write, rd_x, rd_y, rd_en, vblank, ctrl_swap,
        input  rd_color, rd_valid, swap_pending, front_buffer
    );
    modport slave (
        input  fb_x, fb_y, fb_color, fb_write, rd_x, rd_y, rd_en, vblank, ctrl_swap,
        output rd_color, rd_valid, swap_pending, front_buffer
    );
endinterface

// File: rtl/frame_buffer.sv
// frame_buffer: pixel store with registered one-cycle scanout reads and bounds-checked writes.
// Define FB_DOUBLE_BUFFER_EN for a front/back buffer pair swapped during vertical blank.
module frame_buffer #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240
) (
    input logic           clk,
    input logic           reset,
    frame_buffer_if.slave bus
);
    localparam int XW   = $clog2(FB_WIDTH) + 1;
    localparam int YW   = $clog2(FB_HEIGHT) + 1;
    localparam int NPIX = FB_WIDTH * FB_HEIGHT;
    localparam int AW   = $clog2(2 * NPIX);
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int DEPTH = 2 * NPIX;
`else
    localparam int DEPTH = NPIX;
`endif
    localparam int DAW = $clog2(DEPTH);
    localparam logic [XW-1:0] XLIM = XW'(FB_WIDTH);
    localparam logic [YW-1:0] YLIM = YW'(FB_HEIGHT);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] w_wr_base, w_rd_base, w_wr_addr, w_rd_addr;
    logic          w_wr_in, w_rd_in;

`ifdef FB_DOUBLE_BUFFER_EN
    typedef enum logic {SHOWING, PENDING} state_t;
    state_t r_state, w_next;
    logic   r_old_swap, r_front, w_cmd, w_toggle;

    assign w_cmd = !r_old_swap && bus.ctrl_swap;

    always_comb begin
        w_toggle = r_state == PENDING && bus.vblank;
        w_next   = w_toggle ? SHOWING : (r_state == SHOWING && w_cmd) ? PENDING : r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SHOWING;
            r_old_swap <= 1'b0;
            r_front    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_old_swap <= bus.ctrl_swap;
            r_front    <= r_front ^ w_toggle;
        end
    end

    // Both ports use the registered front index, so a swap edge still sees pre-swap buffers.
    assign w_wr_base        = r_front ? AW'(0) : AW'(NPIX);
    assign w_rd_base        = r_front ? AW'(NPIX) : AW'(0);
    assign bus.swap_pending = r_state == PENDING;
    assign bus.front_buffer = r_front;
`else
    logic w_unused;

    assign w_unused         = ^{bus.ctrl_swap, bus.vblank, w_wr_addr[AW-1:DAW], w_rd_addr[AW-1:DAW]};
    assign w_wr_base        = '0;
    assign w_rd_base        = '0;
    assign bus.swap_pending = 1'b0;
    assign bus.front_buffer = 1'b0;
`endif

    assign w_wr_in   = bus.fb_x < XLIM && bus.fb_y < YLIM;
    assign w_rd_in   = bus.rd_x < XLIM && bus.rd_y < YLIM;
    assign w_wr_addr = w_wr_base + AW'(bus.fb_y) * AW'(FB_WIDTH) + AW'(bus.fb_x);
    assign w_rd_addr = w_rd_base + AW'(bus.rd_y) * AW'(FB_WIDTH) + AW'(bus.rd_x);

    always_ff @(posedge clk) begin
        if (bus.fb_write && w_wr_in)
            r_mem[w_wr_addr[DAW-1:0]] <= bus.fb_color;
    end

    // Separate non-blocking read register gives read-first behaviour on address collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd_valid <= 1'b0;
            bus.rd_color <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en)
                bus.rd_color <= w_rd_in ? r_mem[w_rd_addr[DAW-1:0]] : '0;
        end
    end
endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: directed bench with a read scoreboard and a sparse pixel model.
module tb_frame_buffer;
    localparam int W    = 400;
    localparam int H    = 240;
    localparam int NPIX = W * H;
    localparam int XW   = $clog2(W) + 1;
    localparam int YW   = $clog2(H) + 1;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    int          total = 0;
    int          bad = 0;
    logic [15:0] mdl [int];
    logic [15:0] exp_q [$];
    logic        exp_front = 1'b0;
    logic [15:0] last_col = 16'h0;

    frame_buffer_if #(.FB_WIDTH(W), .FB_HEIGHT(H)) bus ();
    frame_buffer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic int addr(input logic b, input int x, input int y);
        return ((DB && b) ? NPIX : 0) + y * W + x;
    endfunction

    task automatic tick();
        logic issued;
        issued = bus.rd_en && !reset;
        if (issued)
            exp_q.push_back((int'(bus.rd_x) < W && int'(bus.rd_y) < H) ?
                mdl[addr(exp_front, int'(bus.rd_x), int'(bus.rd_y))] : 16'h0);
        if (bus.fb_write && !reset && int'(bus.fb_x) < W && int'(bus.fb_y) < H)
            mdl[addr(!exp_front, int'(bus.fb_x), int'(bus.fb_y))] = bus.fb_color;
        @(posedge clk);
        #1;
        if (issued) begin
            chk("rd_valid", 16'(bus.rd_valid), 16'h1);
            last_col = exp_q.pop_front();
            chk("rd_color", bus.rd_color, last_col);
        end else begin
            chk("rd_valid_idle", 16'(bus.rd_valid), 16'h0);
            if (reset) last_col = 16'h0;
            chk("rd_color_hold", bus.rd_color, last_col);
        end
    endtask

    task automatic wr(input int x, input int y, input logic [15:0] c);
        bus.fb_x = XW'(x);
        bus.fb_y = YW'(y);
        bus.fb_color = c;
        bus.fb_write = 1'b1;
        tick();
        bus.fb_write = 1'b0;
    endtask

    task automatic rd(input int x, input int y);
        bus.rd_x = XW'(x);
        bus.rd_y = YW'(y);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic chk_swap(input string tag, input logic pend);
        chk({tag, "_pending"}, 16'(bus.swap_pending), 16'(pend));
        chk({tag, "_front"}, 16'(bus.front_buffer), 16'(exp_front));
    endtask

`ifdef FB_DOUBLE_BUFFER_EN
    task automatic swap();
        bus.ctrl_swap = 1'b1;
        tick();
        bus.ctrl_swap = 1'b0;
        chk_swap("swap_req", 1'b1);
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        exp_front = !exp_front;
        chk_swap("swap_done", 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.fb_x = '0;
        bus.fb_y = '0;
        bus.fb_color = '0;
        bus.fb_write = 1'b0;
        bus.rd_x = '0;
        bus.rd_y = '0;
        bus.rd_en = 1'b0;
        bus.vblank = 1'b0;
        bus.ctrl_swap = 1'b0;
        tick();
        tick();
        chk_swap("reset", 1'b0);
        reset = 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
        wr(3, 5, 16'h1111);
        swap();
        wr(3, 5, 16'h7FFF);
        rd(3, 5);
        swap();
        rd(3, 5);
        wr(0, 1, 16'h1234);
        wr(399, 0, 16'h4321);
        wr(400, 0, 16'hFFFF);
        wr(0, 240, 16'hFFFF);
        swap();
        rd(0, 1);
        rd(399, 0);
        rd(400, 0);
        rd(0, 240);
        tick();
        bus.ctrl_swap = 1'b1;
        tick();
        bus.ctrl_swap = 1'b0;
        repeat (100) tick();
        chk_swap("long_wait", 1'b1);
        bus.vblank = 1'b1;
        tick();
        exp_front = !exp_front;
        chk_swap("long_swap", 1'b0);
        bus.vblank = 1'b0;
        bus.ctrl_swap = 1'b1;
        tick();
        bus.ctrl_swap = 1'b0;
        tick();
        bus.ctrl_swap = 1'b1;
        tick();
        bus.ctrl_swap = 1'b0;
        tick();
        chk_swap("double_req", 1'b1);
        bus.vblank = 1'b1;
        tick();
        exp_front = !exp_front;
        tick();
        chk_swap("no_queue", 1'b0);
        bus.vblank = 1'b0;
        bus.ctrl_swap = 1'b1;
        tick();
        chk_swap("hold_req", 1'b1);
        bus.vblank = 1'b1;
        tick();
        exp_front = !exp_front;
        bus.vblank = 1'b0;
        tick();
        bus.vblank = 1'b1;
        tick();
        chk_swap("hold_once", 1'b0);
        bus.ctrl_swap = 1'b0;
        bus.vblank = 1'b0;
        tick();
        bus.ctrl_swap = 1'b1;
        bus.vblank = 1'b1;
        tick();
        chk_swap("same_edge", 1'b1);
        bus.ctrl_swap = 1'b0;
        tick();
        exp_front = !exp_front;
        chk_swap("next_edge", 1'b0);
        bus.vblank = 1'b0;
        bus.ctrl_swap = 1'b1;
        tick();
        bus.ctrl_swap = 1'b0;
        bus.fb_x = XW'(5);
        bus.fb_y = YW'(5);
        bus.fb_color = 16'hABCD;
        bus.fb_write = 1'b1;
        bus.vblank = 1'b1;
        tick();
        exp_front = !exp_front;
        bus.fb_write = 1'b0;
        bus.vblank = 1'b0;
        rd(5, 5);
        bus.ctrl_swap = 1'b1;
        tick();
        bus.ctrl_swap = 1'b0;
        chk_swap("pre_reset", 1'b1);
        bus.rd_x = XW'(5);
        bus.rd_y = YW'(5);
        bus.rd_en = 1'b1;
        reset = 1'b1;
        tick();
        exp_front = 1'b0;
        chk_swap("mid_reset", 1'b0);
        reset = 1'b0;
        bus.rd_en = 1'b0;
        tick();
`else
        wr(3, 5, 16'h7FFF);
        rd(3, 5);
        wr(0, 1, 16'h1234);
        wr(399, 0, 16'h4321);
        wr(400, 0, 16'hFFFF);
        wr(0, 240, 16'hFFFF);
        rd(0, 1);
        rd(399, 0);
        rd(400, 0);
        rd(0, 240);
        rd(3, 5);
        tick();
        wr(10, 10, 16'h0001);
        bus.fb_x = XW'(10);
        bus.fb_y = YW'(10);
        bus.fb_color = 16'h00FF;
        bus.fb_write = 1'b1;
        bus.rd_x = XW'(10);
        bus.rd_y = YW'(10);
        bus.rd_en = 1'b1;
        tick();
        bus.fb_write = 1'b0;
        bus.rd_en = 1'b0;
        rd(10, 10);
        bus.ctrl_swap = 1'b1;
        bus.vblank = 1'b1;
        tick();
        tick();
        bus.ctrl_swap = 1'b0;
        tick();
        chk_swap("ignored_swap", 1'b0);
        bus.vblank = 1'b0;
        bus.rd_x = XW'(3);
        bus.rd_y = YW'(5);
        bus.rd_en = 1'b1;
        reset = 1'b1;
        tick();
        chk_swap("mid_reset", 1'b0);
        reset = 1'b0;
        bus.rd_en = 1'b0;
        tick();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
